// File: rtl/ahb_bram_bridge.sv
// AHB-Lite slave in front of a simple dual-port BRAM: byte-strobed port-A writes,
// registered port-B reads, two-cycle ERROR response and same-word read-after-write forwarding.
module ahb_bram_bridge #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDRA,
  output logic [3:0]            BRAM_WEA,
  output logic [31:0]           BRAM_DINA,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDRB,
  input  logic [31:0]           BRAM_DOUTB
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;

  logic                  acc_s;
  logic                  illegal_s;
  logic                  wr_ok_s;
  logic                  rd_ok_s;
  logic [3:0]            mask_s;
  logic [ADDR_WIDTH-1:0] word_s;
  logic [31:0]           hrdata_s;
  logic                  unused_s;

  logic [1:0]            state_r;
  logic [3:0]            wea_r;
  logic [ADDR_WIDTH-1:0] addra_r;
  logic                  rd_pend_r;
  logic [3:0]            fwd_mask_r;
  logic [31:0]           fwd_data_r;

  assign unused_s = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  // Address-phase decode: acceptance, legality and byte-lane mask
  always_comb begin
    acc_s  = HSEL & HTRANS[1] & HREADY;
    word_s = HADDR[ADDR_WIDTH+1:2];
    case (HSIZE)
      3'd0: begin
        illegal_s = 1'b0;
        mask_s    = 4'b0001 << HADDR[1:0];
      end
      3'd1: begin
        illegal_s = HADDR[0];
        mask_s    = HADDR[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        illegal_s = (HADDR[1:0] != 2'b00);
        mask_s    = 4'b1111;
      end
      default: begin
        illegal_s = 1'b1;
        mask_s    = 4'b0000;
      end
    endcase
    wr_ok_s = acc_s & ~illegal_s & HWRITE;
    rd_ok_s = acc_s & ~illegal_s & ~HWRITE;
  end

  // Response FSM and data-phase registers; data-phase state only moves while HREADY is high
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      wea_r      <= 4'b0000;
      addra_r    <= '0;
      rd_pend_r  <= 1'b0;
      fwd_mask_r <= 4'b0000;
      fwd_data_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_ERR1: state_r <= ST_ERR2;
        ST_IDLE, ST_ERR2: state_r <= (acc_s & illegal_s) ? ST_ERR1 : ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
      if (HREADY) begin
        wea_r     <= wr_ok_s ? mask_s : 4'b0000;
        rd_pend_r <= rd_ok_s;
        if (wr_ok_s) begin
          addra_r <= word_s;
        end
        // The BRAM is read-first, so a read overlapping a same-word write data phase takes those lanes from HWDATA
        if (rd_ok_s && (wea_r != 4'b0000) && (word_s == addra_r)) begin
          fwd_mask_r <= wea_r;
          fwd_data_r <= HWDATA;
        end else begin
          fwd_mask_r <= 4'b0000;
        end
      end
    end
  end

  // Read data merge: forwarded lanes override BRAM output
  always_comb begin
    hrdata_s = 32'h0000_0000;
    if (rd_pend_r) begin
      for (int i = 0; i < 4; i++) begin
        hrdata_s[8*i +: 8] = fwd_mask_r[i] ? fwd_data_r[8*i +: 8] : BRAM_DOUTB[8*i +: 8];
      end
    end else begin
      hrdata_s = 32'h0000_0000;
    end
  end

  assign HRDATA     = hrdata_s;
  assign HREADYOUT  = (state_r != ST_ERR1);
  assign HRESP      = (state_r != ST_IDLE);
  assign BRAM_WEA   = rst ? 4'b0000 : wea_r;
  assign BRAM_ADDRA = addra_r;
  assign BRAM_DINA  = HWDATA;
  assign BRAM_ADDRB = word_s;

endmodule

// File: tb/tb_ahb_bram_bridge.sv
// Randomized self-checking bench for ahb_bram_bridge: transaction-level memory model
// plus directed scenarios with hand-computed expectations.
module tb_ahb_bram_bridge;
  localparam int AW = 14;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] ID = 2'b00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          hsel, hwrite, hready;
  logic [31:0]   haddr, hwdata;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic          hreadyout, hresp;
  logic [31:0]   hrdata;
  logic [AW-1:0] baddra, baddrb;
  logic [3:0]    bwea;
  logic [31:0]   bdina;
  logic [31:0]   doutb;

  ahb_bram_bridge #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready), .HREADYOUT(hreadyout), .HRESP(hresp),
    .HRDATA(hrdata), .BRAM_ADDRA(baddra), .BRAM_WEA(bwea), .BRAM_DINA(bdina),
    .BRAM_ADDRB(baddrb), .BRAM_DOUTB(doutb)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Environment BRAM, read-first
  logic [31:0] bram [0:(1<<AW)-1];
  always @(posedge clk) begin
    doutb <= bram[baddrb];
    if (bwea != 4'b0000) bram[baddra] <= merge(bram[baddra], bdina, bwea);
  end

  // Reference model: architectural memory plus one pending data phase and error progress
  logic [31:0]   gold [0:(1<<AW)-1];
  int            dp_kind;   // 0 none, 1 write, 2 read
  logic [AW-1:0] dp_word;
  logic [3:0]    dp_mask;
  int            err;       // 0 none, 1 first error cycle, 2 second error cycle
  int            total = 0;
  int            passed = 0;
  logic          cap_ready, cap_resp;
  logic [3:0]    cap_wea;
  logic [31:0]   cap_hrdata;
  logic [AW-1:0] cap_addra;

  function automatic bit legal(input logic [31:0] a, input logic [2:0] sz);
    int bytes;
    if (sz > 3'd2) return 1'b0;
    bytes = 1 << sz;
    return (a % bytes) == 0;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [31:0] a, input logic [2:0] sz);
    int bytes;
    bytes = 1 << sz;
    return 4'(((1 << bytes) - 1) << (a % 4));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic step(input logic sel, input logic [1:0] tr, input logic [31:0] a, input logic [2:0] sz,
                      input logic wr, input logic [31:0] wd, input logic rdy, input logic r);
    logic [3:0] exp_wea;
    bit acc;
    hsel = sel; htrans = tr; haddr = a; hsize = sz; hwrite = wr; hwdata = wd; hready = rdy; rst = r;
    @(negedge clk);
    cap_ready = hreadyout; cap_resp = hresp; cap_wea = bwea; cap_hrdata = hrdata; cap_addra = baddra;
    chk("hreadyout", {31'd0, hreadyout}, {31'd0, err != 1});
    chk("hresp", {31'd0, hresp}, {31'd0, err != 0});
    exp_wea = (!r && dp_kind == 1) ? dp_mask : 4'b0000;
    chk("wea", {28'd0, bwea}, {28'd0, exp_wea});
    if (exp_wea != 4'b0000) begin
      chk("addra", {18'd0, baddra}, {18'd0, dp_word});
      chk("dina", bdina, wd);
    end
    if (!r) chk("hrdata", hrdata, (dp_kind == 2) ? gold[dp_word] : 32'h0);
    if (!r && dp_kind == 1) gold[dp_word] = merge(gold[dp_word], wd, dp_mask);
    acc = sel && tr[1] && rdy;
    if (r) begin
      err = 0; dp_kind = 0;
    end else begin
      err = (err == 1) ? 2 : ((acc && !legal(a, sz)) ? 1 : 0);
      if (rdy) begin
        if (acc && legal(a, sz)) begin
          dp_kind = wr ? 1 : 2; dp_word = a[AW+1:2]; dp_mask = lane_mask(a, sz);
        end else dp_kind = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] wd, input logic rdy);
    step(1'b0, ID, 32'h0, 3'd0, 1'b0, wd, rdy, 1'b0);
  endtask

  initial begin
    logic [3:0]  word, last_word;
    logic [1:0]  off;
    logic [2:0]  sz;
    logic [1:0]  tr;
    logic        rdy, r;
    int          k;
    for (int i = 0; i < (1<<AW); i++) begin
      bram[i] = {4{8'(i)}};
      gold[i] = {4{8'(i)}};
    end
    dp_kind = 0; dp_word = '0; dp_mask = 4'b0000; err = 0; last_word = 4'd0;
    hsel = 1'b0; htrans = ID; haddr = 32'h0; hsize = 3'd0; hwrite = 1'b0; hwdata = 32'h0; hready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    idle(32'h0, 1'b1);
    chk("rst_ready", {31'd0, cap_ready}, 32'd1);
    chk("rst_resp", {31'd0, cap_resp}, 32'd0);
    chk("rst_hrdata", cap_hrdata, 32'h0);

    // 1: word write then read two cycles later
    step(1'b1, NS, 32'h10, 3'd2, 1'b1, 32'h0, 1'b1, 1'b0);
    idle(32'hDEADBEEF, 1'b1);
    chk("t1_wea", {28'd0, cap_wea}, 32'hF);
    chk("t1_addra", {18'd0, cap_addra}, 32'd4);
    step(1'b1, NS, 32'h10, 3'd2, 1'b0, 32'h0, 1'b1, 1'b0);
    idle(32'h0, 1'b1);
    chk("t1_hrdata", cap_hrdata, 32'hDEADBEEF);

    // 2: byte writes over 0xAABBCCDD, read overlaps the second write data phase
    step(1'b1, NS, 32'h20, 3'd2, 1'b1, 32'h0, 1'b1, 1'b0);
    step(1'b1, NS, 32'h21, 3'd0, 1'b1, 32'hAABBCCDD, 1'b1, 1'b0);
    step(1'b1, NS, 32'h22, 3'd0, 1'b1, 32'h00001100, 1'b1, 1'b0);
    chk("t2_wea_b1", {28'd0, cap_wea}, 32'h2);
    step(1'b1, NS, 32'h20, 3'd2, 1'b0, 32'h00220000, 1'b1, 1'b0);
    chk("t2_wea_b2", {28'd0, cap_wea}, 32'h4);
    idle(32'h0, 1'b1);
    chk("t2_hrdata", cap_hrdata, 32'hAA2211DD);

    // 3: back-to-back forwarding, word then half
    step(1'b1, NS, 32'h40, 3'd2, 1'b1, 32'h0, 1'b1, 1'b0);
    step(1'b1, NS, 32'h40, 3'd2, 1'b0, 32'h12345678, 1'b1, 1'b0);
    idle(32'h0, 1'b1);
    chk("t3_fwd_word", cap_hrdata, 32'h12345678);
    step(1'b1, NS, 32'h42, 3'd1, 1'b1, 32'h0, 1'b1, 1'b0);
    step(1'b1, NS, 32'h40, 3'd2, 1'b0, 32'hBEEF0000, 1'b1, 1'b0);
    idle(32'h0, 1'b1);
    chk("t3_fwd_half", cap_hrdata, 32'hBEEF5678);

    // 4: misaligned word read, legal read in the second error cycle
    step(1'b1, NS, 32'h02, 3'd2, 1'b0, 32'h0, 1'b1, 1'b0);
    idle(32'h0, 1'b0);
    chk("t4_err1_ready", {31'd0, cap_ready}, 32'd0);
    chk("t4_err1_resp", {31'd0, cap_resp}, 32'd1);
    step(1'b1, NS, 32'h40, 3'd2, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("t4_err2_ready", {31'd0, cap_ready}, 32'd1);
    chk("t4_err2_resp", {31'd0, cap_resp}, 32'd1);
    idle(32'h0, 1'b1);
    chk("t4_ok_resp", {31'd0, cap_resp}, 32'd0);
    chk("t4_hrdata", cap_hrdata, 32'hBEEF5678);

    // 5: illegal size write leaves memory untouched
    step(1'b1, NS, 32'h40, 3'd3, 1'b1, 32'h0, 1'b1, 1'b0);
    idle(32'hFFFFFFFF, 1'b0);
    chk("t5_wea_err1", {28'd0, cap_wea}, 32'h0);
    idle(32'hFFFFFFFF, 1'b1);
    chk("t5_wea_err2", {28'd0, cap_wea}, 32'h0);
    step(1'b1, NS, 32'h40, 3'd2, 1'b0, 32'h0, 1'b1, 1'b0);
    idle(32'h0, 1'b1);
    chk("t5_readback", cap_hrdata, 32'hBEEF5678);

    // 6: reset during write data phase, then HSEL=0 traffic
    step(1'b1, NS, 32'h50, 3'd2, 1'b1, 32'h0, 1'b1, 1'b0);
    step(1'b0, ID, 32'h0, 3'd0, 1'b0, 32'hCAFEF00D, 1'b1, 1'b1);
    chk("t6_wea_rst", {28'd0, cap_wea}, 32'h0);
    idle(32'h0, 1'b1);
    chk("t6_ready", {31'd0, cap_ready}, 32'd1);
    chk("t6_hrdata", cap_hrdata, 32'h0);
    step(1'b1, NS, 32'h50, 3'd2, 1'b0, 32'h0, 1'b1, 1'b0);
    idle(32'h0, 1'b1);
    chk("t6_readback", cap_hrdata, 32'h14141414);
    step(1'b0, NS, 32'h60, 3'd2, 1'b1, 32'h0, 1'b1, 1'b0);
    idle(32'h55AA55AA, 1'b1);
    chk("t6_nosel_wea", {28'd0, cap_wea}, 32'h0);
    chk("t6_nosel_resp", {31'd0, cap_resp}, 32'd0);

    // Randomized traffic over a small word range with high address bits aliased
    for (int n = 0; n < 800; n++) begin
      k = $urandom_range(0, 7);
      tr = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : {1'b1, k[0]};
      sz = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      word = ($urandom_range(0, 1) == 1) ? last_word : 4'($urandom_range(0, 15));
      last_word = word;
      off = 2'($urandom_range(0, 3));
      if (sz == 3'd2 && $urandom_range(0, 3) != 0) off = 2'b00;
      if (sz == 3'd1 && $urandom_range(0, 3) != 0) off[0] = 1'b0;
      rdy = (err == 1) ? 1'b0 : ((dp_kind == 0 && $urandom_range(0, 7) == 0) ? 1'b0 : 1'b1);
      r = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 9) != 0, tr, {16'($urandom), 10'd0, word, off}, sz,
           1'($urandom_range(0, 1)), $urandom, rdy, r);
    end
    idle(32'h0, 1'b1);
    idle(32'h0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
